// File: rtl/imem_loader_pkg.sv
// Shared constants, state encoding and address helper for the instruction-memory loader.
package loader_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_LEN_HI = S_LEN_HI,
        ST_LEN_LO = S_LEN_LO,
        ST_DATA   = S_DATA,
        ST_CHECK  = S_CHECK,
        ST_DONE   = S_DONE,
        ST_ERR    = S_ERR
    } state_t;

    localparam int          LEN_BYTES         = 2;
    localparam int          BYTES_PER_WORD    = 4;
    localparam int unsigned DEFAULT_DEPTH     = 256;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;

    // Byte address of word number idx relative to base; 32-bit arithmetic throughout.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words; flags each completed word for one cycle.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic [7:0]  i_byte,
    input  logic        i_strobe,
    output logic [31:0] o_word,
    output logic        o_word_ready,
    output logic [1:0]  o_byte_idx
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [31:0] r_word;
    logic        r_word_ready;
    logic [1:0]  r_byte_idx;

    always_ff @(posedge clk) begin
        // NOTE: rst and clear share one branch so an aborted load can never leave a partial word behind.
        if (rst || i_clear) begin
            r_word       <= 32'd0;
            r_word_ready <= 1'b0;
            r_byte_idx   <= 2'd0;
        end else begin
            r_word_ready <= i_strobe && (r_byte_idx == LAST_IDX);
            if (i_strobe) begin
                r_word     <= {r_word[23:0], i_byte};
                r_byte_idx <= r_byte_idx + 2'd1;
            end
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = r_word_ready;
    assign o_byte_idx   = r_byte_idx;

endmodule

// File: rtl/imem_loader.sv
// Receives a length-prefixed, XOR-checksummed program image and writes it into instruction memory,
// holding the pipeline in reset until a complete image has been verified.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err,
    output logic [15:0] word_count
);

    localparam int LEN_W = LEN_BYTES * 8;

    state_t             r_state;
    logic               r_byte_ready;
    logic [31:0]        r_im_addr;
    logic               r_cpu_rst;
    logic               r_done;
    logic               r_err;
    logic [15:0]        r_word_count;
    logic [7:0]         r_len_hi;
    logic [LEN_W-1:0]   r_len;
    logic [7:0]         r_csum;

    logic               w_xfer;
    logic               w_strobe;
    logic               w_last_byte;
    logic               w_clear;
    logic [LEN_W-1:0]   w_len;
    logic [31:0]        w_word;
    logic               w_word_ready;
    logic [1:0]         w_byte_idx;

    assign w_xfer      = byte_valid && r_byte_ready;
    assign w_strobe    = w_xfer && (r_state == ST_DATA);
    assign w_last_byte = w_strobe && (w_byte_idx == 2'(BYTES_PER_WORD - 1));
    assign w_clear     = load_start && (r_state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign w_len       = {r_len_hi, byte_data};

    word_assembler u_word_assembler (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_byte       (byte_data),
        .i_strobe     (w_strobe),
        .o_word       (w_word),
        .o_word_ready (w_word_ready),
        .o_byte_idx   (w_byte_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_byte_ready <= 1'b0;
            r_im_addr    <= BASE_ADDR;
            r_cpu_rst    <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= 16'd0;
            r_len_hi     <= 8'd0;
            r_len        <= '0;
            r_csum       <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (load_start) begin
                        r_state      <= ST_LEN_HI;
                        r_byte_ready <= 1'b1;
                        r_cpu_rst    <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_word_count <= 16'd0;
                        r_csum       <= 8'd0;
                    end
                end

                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= byte_data;
                        r_state  <= ST_LEN_LO;
                    end
                end

                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if (w_len == '0) begin
                            r_state <= ST_CHECK;
                        end else if (32'(w_len) > DEPTH) begin
                            r_state      <= ST_ERR;
                            r_err        <= 1'b1;
                            r_byte_ready <= 1'b0;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    // Ready drops for exactly the cycle the assembled word is on the write port.
                    r_byte_ready <= !w_last_byte;
                    if (w_strobe) begin
                        r_csum <= r_csum ^ byte_data;
                    end
                    if (w_last_byte) begin
                        r_im_addr    <= word_addr(BASE_ADDR, r_word_count);
                        r_word_count <= r_word_count + 16'd1;
                        if ((r_word_count + 16'd1) == r_len) begin
                            r_state <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    r_byte_ready <= 1'b1;
                    if (w_xfer) begin
                        r_byte_ready <= 1'b0;
                        if (byte_data == r_csum) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_ready <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = r_byte_ready;
    assign im_we      = w_word_ready;
    assign im_addr    = r_im_addr;
    assign im_wdata   = w_word;
    assign cpu_rst    = r_cpu_rst;
    assign done       = r_done;
    assign err        = r_err;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames compared against a frame-level model.
module tb_imem_loader;

    localparam int unsigned DEPTH     = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    int          n_checks   = 0;
    int          n_fails    = 0;
    int          ready_viol = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  frame[$];

    // Capture every memory write; byte_ready must be low whenever a write is on the port.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_addr_q.push_back(im_addr);
            wr_data_q.push_back(im_wdata);
            if (byte_ready !== 1'b0) ready_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_byte_ready"}, byte_ready, 0);
        check({tag, "_im_we"},      im_we,      0);
        check({tag, "_im_addr"},    im_addr,    BASE_ADDR);
        check({tag, "_im_wdata"},   im_wdata,   0);
        check({tag, "_cpu_rst"},    cpu_rst,    1);
        check({tag, "_done"},       done,       0);
        check({tag, "_err"},        err,        0);
        check({tag, "_word_count"}, word_count, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Offers each byte until the loader takes it; gap_pct is the chance of idling a cycle instead.
    task automatic send_bytes(input logic [7:0] bytes[$], input int gap_pct);
        foreach (bytes[i]) begin
            int waited = 0;
            bit sent   = 1'b0;
            while (!sent) begin
                @(negedge clk);
                if ($urandom_range(99) < gap_pct) begin
                    byte_valid = 1'b0;
                end else begin
                    byte_valid = 1'b1;
                    byte_data  = bytes[i];
                    if (byte_ready === 1'b1) sent = 1'b1;
                end
                waited++;
                if (!sent && waited > 200) begin
                    n_checks++;
                    n_fails++;
                    $error("FAIL xfer_timeout: byte %0d observed no acceptance in %0d cycles, expected acceptance", i, waited);
                    @(negedge clk);
                    byte_valid = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Builds a well-formed frame of n random words; corrupt flips bits of the checksum byte.
    task automatic make_frame(input int n, input bit corrupt, output logic [7:0] f[$]);
        logic [7:0] cs;
        logic [7:0] b;
        f  = {};
        cs = 8'd0;
        f.push_back(8'(n >> 8));
        f.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs ^= b;
            f.push_back(b);
        end
        if (corrupt) cs ^= 8'($urandom_range(1, 255));
        f.push_back(cs);
    endtask

    // Derives the expected outcome of a frame from the framing rules, then runs and compares it.
    task automatic run_load(input string name, input logic [7:0] f[$], input int gap_pct);
        int          n;
        int          consumed;
        bit          exp_done;
        logic [7:0]  cs;
        logic [31:0] exp_addr[$];
        logic [31:0] exp_data[$];
        logic [7:0]  tx[$];

        n  = int'({f[0], f[1]});
        cs = 8'd0;
        if (n > int'(DEPTH)) begin
            consumed = 2;
            exp_done = 1'b0;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(BASE_ADDR + 32'(4 * i));
                exp_data.push_back({f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]});
                for (int k = 0; k < 4; k++) cs ^= f[2+4*i+k];
            end
            consumed = 2 + 4 * n + 1;
            exp_done = (f[2+4*n] == cs);
        end

        wr_addr_q.delete();
        wr_data_q.delete();
        ready_viol = 0;
        pulse_start();
        tx = f[0:consumed-1];
        send_bytes(tx, gap_pct);
        repeat (4) @(negedge clk);

        check({name, "_done"},       done,       exp_done);
        check({name, "_err"},        err,        !exp_done);
        check({name, "_cpu_rst"},    cpu_rst,    !exp_done);
        check({name, "_word_count"}, word_count, (n > int'(DEPTH)) ? 0 : n);
        check({name, "_byte_ready"}, byte_ready, 0);
        check({name, "_n_writes"},   wr_addr_q.size(), exp_addr.size());
        check({name, "_ready_in_we"}, ready_viol, 0);
        foreach (exp_addr[i]) begin
            if (i < wr_addr_q.size()) begin
                check($sformatf("%s_addr%0d", name, i), wr_addr_q[i], exp_addr[i]);
                check($sformatf("%s_data%0d", name, i), wr_data_q[i], exp_data[i]);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("idle");

        // XOR of the eight data bytes below is 0x55.
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
        run_load("nominal", frame, 0);
        if (wr_data_q.size() == 2) begin
            check("nominal_word0_const", wr_data_q[0], 32'h2008_0005);
            check("nominal_word1_const", wr_data_q[1], 32'h0109_5020);
            check("nominal_addr1_const", wr_addr_q[1], 32'h0000_0004);
        end

        frame[10] = 8'h00;
        run_load("bad_csum", frame, 0);
        frame[10] = 8'h29;
        run_load("csum_29", frame, 0);

        frame = '{8'h01, 8'h01};
        run_load("overflow", frame, 0);
        frame = '{8'h01, 8'h00, 8'h00};
        frame = '{8'h00, 8'h00, 8'h00};
        run_load("zero_len", frame, 0);
        frame = '{8'h00, 8'h00, 8'h01};
        run_load("zero_len_bad", frame, 0);

        make_frame(3, 1'b0, frame);
        run_load("gaps_n3", frame, 40);
        for (int k = 0; k < 4; k++) begin
            make_frame(int'($urandom_range(1, 8)), ($urandom_range(0, 2) == 0), frame);
            run_load($sformatf("rand%0d", k), frame, 30);
        end

        // Reset in the middle of the first word: nothing may be written, then a clean reload.
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        frame = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send_bytes(frame, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_reset("midrst_idle");
        check("midrst_n_writes", wr_addr_q.size(), 0);

        frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        run_load("after_rst", frame, 20);
        if (wr_data_q.size() == 1) begin
            check("after_rst_word_const", wr_data_q[0], 32'h1234_5678);
            check("after_rst_addr_const", wr_addr_q[0], BASE_ADDR);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
